// File: rtl/chip8_pkg.sv
// Shared encodings and constants for the CHIP-8 memory-side blocks.
package chip8_pkg;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 8;
  localparam int REG_IDX_W = 4;
  localparam int MEM_SIZE  = 4096;

  localparam logic [ADDR_W-1:0] FONT_BASE = 12'h000;
  localparam logic [ADDR_W-1:0] ROM_BASE  = 12'h200;

  typedef enum logic [1:0] {
    OP_FETCH = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/chip8_mem_master.sv
// Memory initiator for CHIP-8: opcode fetch, burst LOAD into V registers and
// burst STORE from V registers against a 1-cycle registered-read byte memory.
module chip8_mem_master
  import chip8_pkg::*;
#(
  parameter int ADDR_W    = chip8_pkg::ADDR_W,
  parameter int DATA_W    = chip8_pkg::DATA_W,
  parameter int REG_IDX_W = chip8_pkg::REG_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [REG_IDX_W-1:0] cmd_len,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_write_en,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [REG_IDX_W-1:0] reg_idx,
  output logic                 reg_we,
  output logic [DATA_W-1:0]    reg_wdata,
  input  logic [DATA_W-1:0]    reg_rdata,
  output logic [15:0]          opcode,
  output logic                 opcode_valid,
  output logic                 done
);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [REG_IDX_W-1:0] k_q, k_d;
  logic [REG_IDX_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic                 mem_we_q, mem_we_d;
  logic [REG_IDX_W-1:0] reg_idx_q, reg_idx_d;
  logic                 reg_we_q, reg_we_d;
  logic [DATA_W-1:0]    hi_q, hi_d;
  logic [15:0]          opcode_q, opcode_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_FETCH;
      k_q        <= '0;
      len_q      <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      reg_idx_q  <= '0;
      reg_we_q   <= 1'b0;
      hi_q       <= '0;
      opcode_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      k_q        <= k_d;
      len_q      <= len_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      reg_idx_q  <= reg_idx_d;
      reg_we_q   <= reg_we_d;
      hi_q       <= hi_d;
      opcode_q   <= opcode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    k_d        = k_q;
    len_d      = len_q;
    mem_addr_d = mem_addr_q;
    mem_we_d   = 1'b0;
    reg_idx_d  = reg_idx_q;
    reg_we_d   = 1'b0;
    hi_d       = hi_q;
    opcode_d   = opcode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d      = op_e'(cmd_op);
          k_d       = '0;
          reg_idx_d = '0;
          if (op_e'(cmd_op) == OP_RSVD) begin
            state_d = ST_DONE;
          end else begin
            // First address goes out on the accept edge so it is on the bus in cycle 1.
            state_d    = ST_RUN;
            mem_addr_d = cmd_addr;
            mem_we_d   = (op_e'(cmd_op) == OP_STORE);
            len_d      = (op_e'(cmd_op) == OP_FETCH) ? REG_IDX_W'(1) : cmd_len;
          end
        end
      end
      ST_RUN: begin
        // Read data trails its address by one cycle, so k==1 sees byte A.
        if (op_q == OP_FETCH && k_q == REG_IDX_W'(1)) hi_d = mem_rdata;
        if (op_q == OP_LOAD) begin
          reg_we_d  = 1'b1;
          reg_idx_d = k_q;
        end
        if (k_q == len_q) begin
          state_d = (op_q == OP_STORE) ? ST_DONE : ST_DRAIN;
        end else begin
          k_d        = k_q + REG_IDX_W'(1);
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          if (op_q == OP_STORE) begin
            mem_we_d  = 1'b1;
            reg_idx_d = k_q + REG_IDX_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (op_q == OP_FETCH) opcode_d = {hi_q, mem_rdata};
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready    = (state_q == ST_IDLE) && !rst;
  assign mem_addr     = mem_addr_q;
  assign mem_write_en = mem_we_q;
  assign mem_wdata    = mem_we_q ? reg_rdata : '0;
  assign reg_idx      = reg_idx_q;
  assign reg_we       = reg_we_q;
  assign reg_wdata    = reg_we_q ? mem_rdata : '0;
  assign opcode       = opcode_q;
  assign done         = (state_q == ST_DONE);
  assign opcode_valid = (state_q == ST_DONE) && (op_q == OP_FETCH);

endmodule

// File: tb/tb_chip8_mem_master.sv
// Directed scoreboard bench for chip8_mem_master with a behavioural memory and V-register file.
module tb_chip8_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [11:0] mem_addr;
  logic        mem_write_en;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [3:0]  reg_idx;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic [15:0] opcode;
  logic        opcode_valid;
  logic        done;

  chip8_mem_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .reg_idx(reg_idx), .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .opcode(opcode), .opcode_valid(opcode_valid), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural memory, register file and cycle counter
  logic [7:0]  mem [4096];
  logic [7:0]  vreg [16];
  logic        pk_mem = 1'b0, pk_reg = 1'b0;
  logic [11:0] pk_a = '0;
  logic [7:0]  pk_d = '0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata <= mem[mem_addr];
    if (mem_write_en) mem[mem_addr] <= mem_wdata;
    else if (pk_mem) mem[pk_a] <= pk_d;
    if (reg_we) vreg[reg_idx] <= reg_wdata;
    else if (pk_reg) vreg[pk_a[3:0]] <= pk_d;
  end
  assign reg_rdata = vreg[reg_idx];

  typedef struct {int cyc; logic [11:0] a; logic [15:0] d;} ev_t;
  ev_t exp_mw[$], exp_rw[$], exp_ma[$], exp_op[$];
  int  exp_done[$];
  int  errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: every strobe the DUT produces is matched against the scoreboard
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (mem_write_en) begin
        if (exp_mw.size() == 0) chk("mw_unexpected", {31'd0, mem_write_en}, 32'd0);
        else begin
          e = exp_mw.pop_front();
          chk("mw_cyc", cyc, e.cyc);
          chk("mw_addr", {20'd0, mem_addr}, {20'd0, e.a});
          chk("mw_data", {24'd0, mem_wdata}, {16'd0, e.d});
        end
      end
      if (reg_we) begin
        if (exp_rw.size() == 0) chk("rw_unexpected", {31'd0, reg_we}, 32'd0);
        else begin
          e = exp_rw.pop_front();
          chk("rw_cyc", cyc, e.cyc);
          chk("rw_idx", {28'd0, reg_idx}, {20'd0, e.a});
          chk("rw_data", {24'd0, reg_wdata}, {16'd0, e.d});
        end
      end
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", {31'd0, done}, 32'd0);
        else chk("done_cyc", cyc, exp_done.pop_front());
      end
      if (opcode_valid) begin
        if (exp_op.size() == 0) chk("opv_unexpected", {31'd0, opcode_valid}, 32'd0);
        else begin
          e = exp_op.pop_front();
          chk("opv_cyc", cyc, e.cyc);
          chk("opcode", {16'd0, opcode}, {16'd0, e.d});
        end
      end
      if (exp_ma.size() != 0 && exp_ma[0].cyc == cyc) begin
        e = exp_ma.pop_front();
        chk("mem_addr", {20'd0, mem_addr}, {20'd0, e.a});
      end
    end
  end

  task automatic poke_mem(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk); pk_mem = 1'b1; pk_a = a; pk_d = d;
    @(negedge clk); pk_mem = 1'b0;
  endtask

  task automatic poke_reg(input logic [3:0] i, input logic [7:0] d);
    @(negedge clk); pk_reg = 1'b1; pk_a = {8'd0, i}; pk_d = d;
    @(negedge clk); pk_reg = 1'b0;
  endtask

  // Returns b such that cycle c after the accept edge has cyc == b + c
  task automatic issue(input logic [1:0] op, input logic [11:0] a, input logic [3:0] len,
                       input logic hold, output int b);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = len;
    chk("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    b = cyc - 1;
  endtask

  task automatic settle(input string tag, input int n);
    repeat (n) @(posedge clk);
    #1;
    chk({tag, "_mw_left"}, exp_mw.size(), 0);
    chk({tag, "_rw_left"}, exp_rw.size(), 0);
    chk({tag, "_done_left"}, exp_done.size(), 0);
    chk({tag, "_op_left"}, exp_op.size() + exp_ma.size(), 0);
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic expect_fetch(input int b, input logic [11:0] a, input logic [15:0] op);
    exp_ma.push_back('{b + 1, a, 16'd0});
    exp_ma.push_back('{b + 2, a + 12'd1, 16'd0});
    exp_op.push_back('{b + 4, 12'd0, op});
    exp_done.push_back(b + 4);
  endtask

  initial begin
    int b;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_outs", {mem_addr, mem_write_en, reg_we, done, opcode_valid, reg_idx},
        32'd0);
    chk("rst_opcode", {16'd0, opcode}, 32'd0);
    @(negedge clk); rst = 1'b0;

    poke_mem(12'h200, 8'h00); poke_mem(12'h201, 8'hE0);
    poke_mem(12'hFFF, 8'h12); poke_mem(12'h000, 8'hF0);
    for (int k = 0; k < 16; k++) poke_mem(12'h300 + 12'(k), 8'(3 * k));

    // FETCH at ROM_BASE
    issue(2'b00, 12'h200, 4'd7, 1'b0, b);
    expect_fetch(b, 12'h200, 16'h00E0);
    settle("fetch200", 6);
    chk("fetch200_hold", {16'd0, opcode}, 32'h00E0);

    // FETCH across the address wrap
    issue(2'b00, 12'hFFF, 4'd0, 1'b0, b);
    expect_fetch(b, 12'hFFF, 16'h12F0);
    settle("fetchFFF", 6);

    // LOAD of 16 bytes with cmd_valid held and a pending reserved op
    issue(2'b01, 12'h300, 4'd15, 1'b1, b);
    for (int k = 0; k < 16; k++) exp_rw.push_back('{b + k + 2, 12'(k), 16'(3 * k)});
    exp_done.push_back(b + 18);
    exp_done.push_back(b + 20);
    cmd_op = 2'b11;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      chk($sformatf("load_ready_c%0d", c), {31'd0, cmd_ready}, {31'd0, c == 19});
      if (c < 19) cmd_addr = 12'($urandom);
    end
    @(posedge clk); #1; cmd_valid = 1'b0;
    settle("load_rsvd", 4);
    chk("load_v15", {24'd0, vreg[15]}, 32'd45);

    // STORE of BCD digits of 159
    poke_reg(4'd0, 8'd1); poke_reg(4'd1, 8'd5); poke_reg(4'd2, 8'd9);
    issue(2'b10, 12'h400, 4'd2, 1'b0, b);
    exp_mw.push_back('{b + 1, 12'h400, 16'd1});
    exp_mw.push_back('{b + 2, 12'h401, 16'd5});
    exp_mw.push_back('{b + 3, 12'h402, 16'd9});
    exp_done.push_back(b + 4);
    settle("store", 6);
    chk("store_mem", {8'd0, mem[12'h400], mem[12'h401], mem[12'h402]}, 32'h00010509);

    // Reset in the middle of a 4-byte STORE
    for (int k = 0; k < 4; k++) begin
      poke_mem(12'h400 + 12'(k), 8'hAA);
      poke_reg(4'(k), 8'(8'h11 * (k + 1)));
    end
    issue(2'b10, 12'h400, 4'd3, 1'b0, b);
    exp_mw.push_back('{b + 1, 12'h400, 16'h11});
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_mwe", {31'd0, mem_write_en}, 32'd0);
    chk("abort_outs", {mem_addr, reg_we, done, opcode_valid, cmd_ready, reg_idx}, 32'd0);
    chk("abort_opcode", {16'd0, opcode}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle("abort", 4);
    chk("abort_mem400", {24'd0, mem[12'h400]}, 32'h11);
    chk("abort_mem401", {24'd0, mem[12'h401]}, 32'hAA);

    // Normal FETCH after the aborted command
    issue(2'b00, 12'h200, 4'd0, 1'b0, b);
    expect_fetch(b, 12'h200, 16'h00E0);
    settle("fetch_after_rst", 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chip8_mem_master.md
Name: chip8_mem_master

Overview:
- Memory-side initiator for the CHIP-8 byte memory: the only block that drives the memory's address, write-enable and write-data inputs, and the only consumer of its read data.
- Serves three CPU commands: opcode fetch (two bytes assembled big-endian), burst LOAD into V registers (Fx65), and burst STORE from V registers (Fx55, Fx33 BCD).
- Sits between the CPU control FSM / register file and the 4 KiB memory, which has a 1-cycle registered read and a synchronous write.

Parameters:
- ADDR_W, 12, memory address width; all address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8, memory byte width.
- REG_IDX_W, 4, V-register index width (16 registers).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on the edge where cmd_valid && cmd_ready.
- cmd_op  in  2  00 FETCH, 01 LOAD, 10 STORE, 11 reserved.
- cmd_addr  in  ADDR_W  start address (PC or I).
- cmd_len  in  REG_IDX_W  byte count minus 1 (0..15 gives 1..16 bytes); ignored for FETCH, which always transfers 2 bytes.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_write_en  out  1  memory write strobe, registered.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after its address.
- reg_idx  out  REG_IDX_W  V-register index for read or write.
- reg_we  out  1  V-register write strobe.
- reg_wdata  out  DATA_W  V-register write data.
- reg_rdata  in  DATA_W  combinational V[reg_idx] read data.
- opcode  out  16  last fetched opcode; held until the next FETCH completes.
- opcode_valid  out  1  one-cycle pulse when opcode updates.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: asynchronous, active-high. While rst is high and after release, all outputs are 0 and state is IDLE.
  - mem_write_en and reg_we must drop the same instant rst rises; no partial write may follow.
  - An aborted command is lost; it produces no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
- Accept (edge E0): latch cmd_op, cmd_addr, cmd_len into internal registers; clear byte counter k. Command inputs are ignored while busy.
- Timing below counts cycle c = the c-th cycle after E0; n = byte count.
- FETCH (n=2), address A:
  - Cycle 1: mem_addr = A.
  - Cycle 2: mem_addr = A+1; mem_rdata captured as the high byte.
  - Cycle 3: mem_rdata is the low byte; opcode = {hi, lo} registered at the end of cycle 3.
  - Cycle 4: opcode_valid = 1, done = 1.
  - mem_write_en stays 0 throughout.
- LOAD, address A, n bytes:
  - Address phase: cycles k+1 for k = 0..n-1, mem_addr = A+k (1 byte/cycle, pipelined).
  - Data phase: cycles k+2 give reg_we = 1, reg_idx = k, reg_wdata = mem_rdata.
  - done in cycle n+2.
- STORE, address A, n bytes:
  - Cycles k+1 for k = 0..n-1: reg_idx = k, mem_addr = A+k, mem_write_en = 1, mem_wdata = reg_rdata.
  - done in cycle n+1. reg_we stays 0.
- Reserved op: no memory or register activity; done in cycle 1.
- State flow:
  - RUN issues addresses.
  - DRAIN covers the single trailing read-data cycle (FETCH/LOAD only).
  - DONE asserts done for 1 cycle, then returns to IDLE.
  - cmd_ready rises the cycle after done, so minimum command spacing is the listed latency + 1.
- Address wrap: A+k computed in ADDR_W bits, so 0xFFF+1 = 0x000. Odd start addresses are legal.
- Idle outputs: mem_addr holds its last value; mem_write_en, reg_we, done and opcode_valid are 0.

Decomposition:
- Package chip8_pkg holds:
  - Op encodings: OP_FETCH, OP_LOAD, OP_STORE, OP_RSVD.
  - The state enum.
  - Constants ADDR_W, DATA_W, REG_IDX_W, MEM_SIZE = 4096, FONT_BASE = 0x000, ROM_BASE = 0x200.
- Single flat module; no sub-module. The counter and address incrementer are inline.

Test Plan:
- FETCH at 0x200 with mem[0x200..0x201] = 00 E0 -> mem_addr 0x200 in cycle 1 and 0x201 in cycle 2; opcode = 0x00E0 with opcode_valid and done in cycle 4; mem_write_en never high.
- FETCH at 0xFFF with mem[0xFFF] = 0x12 and mem[0x000] = 0xF0 (font "0") -> mem_addr goes 0xFFF then 0x000; opcode = 0x12F0.
- LOAD A = 0x300, cmd_len = 15, mem[0x300+k] = k*3 -> reg_we in cycles 2..17 with reg_idx = k and reg_wdata = 3k; done in cycle 18; cmd_ready in cycle 19.
- STORE A = 0x400, cmd_len = 2, V0..V2 = 1,5,9 (BCD of 159) -> writes to 0x400..0x402 in cycles 1..3 with data 01,05,09; done in cycle 4; mem readback matches.
- Reset mid-STORE: assert rst asynchronously during cycle 2 of a 4-byte STORE -> mem_write_en falls immediately; only 0x400 and (if the edge passed) 0x401 are written; no done pulse; after release, FETCH works normally.
- cmd_valid held high with a changing cmd_addr during a LOAD -> ignored (cmd_ready = 0); the next command is accepted on the first IDLE cycle; the reserved op gives done in cycle 1 with no strobes.
